// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage and imem: req/gnt handshake with a
// single outstanding read whose data returns later on rvalid/rdata.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: owns the fetch PC, keeps one imem read in flight and
// parks a response that returns during a stall in a 1-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [31:0]          pcTarget_E,
    fetch_stage_if.master        imem,
    output logic [31:0]          instr_D,
    output logic [31:0]          pc_D,
    output logic [31:0]          pcPlus4_D,
    output logic                 valid_D
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_f;
    logic [31:0] req_pc;
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic        rsp_take;
    logic        req;
    logic        grant;

    // A wanted response is one that returns while WAIT; DROP responses are swallowed.
    assign rsp_take  = (state == WAIT) && imem.rvalid;

    // Re-requesting in the same cycle a response lands keeps zero-wait memory at 1 instr/cycle.
    assign req       = !rst && !flush && !buf_valid &&
                       ((state == IDLE) || (rsp_take && !stall));
    assign grant     = req && imem.gnt;

    assign imem.req  = req;
    assign imem.addr = {pc_f[31:2], 2'b00};

    always_comb begin
        state_nxt = state;
        if (flush) begin
            case (state)
                WAIT:    state_nxt = imem.rvalid ? IDLE : DROP;
                DROP:    state_nxt = imem.rvalid ? IDLE : DROP;
                default: state_nxt = IDLE;
            endcase
        end else if (grant) begin
            state_nxt = WAIT;
        end else if (imem.rvalid && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f   <= RESET_PC;
            req_pc <= 32'h0;
        end else begin
            if (flush) begin
                pc_f <= {pcTarget_E[31:2], 2'b00};
            end else if (grant) begin
                pc_f <= pc_f + 32'd4;
            end
            if (grant) begin
                req_pc <= pc_f;
            end
        end
    end

    // Skid buffer: filled by a stalled response, drained into IF/ID on the first free cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= 32'h0;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end else if (rsp_take && stall) begin
            buf_valid <= 1'b1;
            buf_instr <= imem.rdata;
            buf_pc    <= req_pc;
        end else if (!stall) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_D   <= 1'b0;
            instr_D   <= NOP_INSTR;
            pc_D      <= 32'h0;
            pcPlus4_D <= 32'h0;
        end else if (flush) begin
            valid_D   <= 1'b0;
            instr_D   <= NOP_INSTR;
        end else if (!stall) begin
            if (buf_valid) begin
                valid_D   <= 1'b1;
                instr_D   <= buf_instr;
                pc_D      <= buf_pc;
                pcPlus4_D <= buf_pc + 32'd4;
            end else if (rsp_take) begin
                valid_D   <= 1'b1;
                instr_D   <= imem.rdata;
                pc_D      <= req_pc;
                pcPlus4_D <= req_pc + 32'd4;
            end else begin
                valid_D   <= 1'b0;
                instr_D   <= NOP_INSTR;
            end
        end
    end

    a_buf_blocks_req: assert property (@(posedge clk) disable iff (rst) buf_valid |-> !req);
    a_no_req_in_drop: assert property (@(posedge clk) disable iff (rst) (state == DROP) |-> !req);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a latency-programmable imem model plus an in-order
// fetch/deliver reference predicting every IF/ID value and every request.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] pcTarget_E;
    logic [31:0] instr_D, pc_D, pcPlus4_D;
    logic        valid_D;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcTarget_E(pcTarget_E),
        .imem(imem.master),
        .instr_D(instr_D), .pc_D(pc_D), .pcPlus4_D(pcPlus4_D), .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory model knobs and state
    int          gnt_pct = 100, lat_min = 1, lat_max = 1;
    logic        spur = 1'b0;
    logic        pend = 1'b0, pend_live = 1'b0;
    int          pend_due = 0;
    logic [31:0] pend_addr = 32'h0;
    int          cyc = 0;

    // reference model: program-order fetch address and wanted responses awaiting IF/ID
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] fifo[$];
    logic        m_valid = 1'b0, pc_known = 1'b0;
    logic [31:0] m_instr = NOP_INSTR, m_pc = 32'h0, m_pc4 = 32'h0;
    int          delivered = 0;

    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] tgt);
        logic        rv, bufd, grant;
        logic [31:0] a;
        rst = r; stall = s; flush = f; pcTarget_E = tgt;
        rv = pend && (cyc == pend_due);
        imem.rdata  = rv ? word(pend_addr) : $urandom;
        if (spur && !pend) rv = 1'b1;
        imem.rvalid = rv;
        imem.gnt    = 1'b0;
        #1;
        bufd = (fifo.size() != 0);
        if (r || f)           chk("req_off",  {31'h0, imem.req}, 32'h0);
        else if (bufd)        chk("req_buf",  {31'h0, imem.req}, 32'h0);
        else if (!pend)       chk("req_idle", {31'h0, imem.req}, 32'h1);
        else if (rv)          chk("req_rsp",  {31'h0, imem.req}, {31'h0, pend_live && !s});
        else                  chk("req_wait", {31'h0, imem.req}, 32'h0);
        if (imem.req) chk("addr", imem.addr, exp_fetch);
        imem.gnt = ($urandom_range(0, 99) < gnt_pct);
        #1;
        grant = imem.req && imem.gnt;
        if (rv && pend) begin
            if (pend_live && !f && !r) fifo.push_back(pend_addr);
            pend = 1'b0;
        end
        if (grant) begin
            chk("one_outstanding", {31'h0, pend}, 32'h0);
            pend      = 1'b1;
            pend_live = 1'b1;
            pend_addr = exp_fetch;
            pend_due  = cyc + $urandom_range(lat_min, lat_max);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (f) begin
            pend_live = 1'b0;
            fifo.delete();
            exp_fetch = tgt & ~32'h3;
        end
        if (r) begin
            pend = 1'b0; fifo.delete(); exp_fetch = RESET_PC;
            m_valid = 1'b0; m_instr = NOP_INSTR; m_pc = 32'h0; m_pc4 = 32'h0; pc_known = 1'b1;
        end else if (f) begin
            m_valid = 1'b0; m_instr = NOP_INSTR; pc_known = 1'b0;
        end else if (!s) begin
            if (fifo.size() != 0) begin
                a = fifo.pop_front();
                m_valid = 1'b1; m_instr = word(a); m_pc = a; m_pc4 = a + 32'd4;
                pc_known = 1'b1; delivered++;
            end else begin
                m_valid = 1'b0; m_instr = NOP_INSTR; pc_known = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("valid_D", {31'h0, valid_D}, {31'h0, m_valid});
        chk("instr_D", instr_D, m_instr);
        if (pc_known) begin
            chk("pc_D", pc_D, m_pc);
            chk("pcPlus4_D", pcPlus4_D, m_pc4);
        end
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        for (int i = 0; i < 30; i++) begin
            if (valid_D) break;
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk({tag, "_valid"}, {31'h0, valid_D}, 32'h1);
        chk({tag, "_pc"}, pc_D, exp_pc);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pcTarget_E = 32'h0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_valid", {31'h0, valid_D}, 32'h0);
        chk("rst_instr", instr_D, NOP_INSTR);
        chk("rst_pc", pc_D, 32'h0);

        // zero-wait streaming
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        // response lands during a 2-cycle stall and goes through the skid buffer
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        // slow response killed by a flush
        lat_min = 4; lat_max = 4;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h100);
        wait_valid("redirect", 32'h100);

        // flush beats stall
        step(1'b0, 1'b1, 1'b1, 32'h40);
        chk("fs_instr", instr_D, NOP_INSTR);
        wait_valid("flush_stall", 32'h40);

        // PC wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid("wrap", 32'hFFFF_FFFC);
        chk("wrap_pc4", pcPlus4_D, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_next", pc_D, 32'h0);

        // reset while a request is outstanding, then a stray rvalid in IDLE
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst2_valid", {31'h0, valid_D}, 32'h0);
        chk("rst2_pc4", pcPlus4_D, 32'h0);
        lat_min = 1; lat_max = 1;
        spur = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        spur = 1'b0;
        wait_valid("post_rst", RESET_PC);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                gnt_pct = $urandom_range(30, 100);
                lat_min = 1;
                lat_max = $urandom_range(1, 5);
            end
            step($urandom_range(0, 999) < 3,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 6,
                 $urandom);
        end
        chk("delivered_enough", {31'h0, delivered >= 300}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
